// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the adding-machine control unit: state encoding,
// opcode values and a small state-classification helper.
package adder_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE  = 4'd0;
    localparam state_t ST_INIT  = 4'd1;
    localparam state_t ST_F1    = 4'd2;
    localparam state_t ST_F2    = 4'd3;
    localparam state_t ST_DEC   = 4'd4;
    localparam state_t ST_A1    = 4'd5;
    localparam state_t ST_A2    = 4'd6;
    localparam state_t ST_S1    = 4'd7;
    localparam state_t ST_S2    = 4'd8;
    localparam state_t ST_J1    = 4'd9;
    localparam state_t ST_HALT  = 4'd10;
    localparam state_t ST_ERROR = 4'd11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_STO = 2'b01;
    localparam logic [1:0] OP_JMP = 2'b10;
    localparam logic [1:0] OP_HLT = 2'b11;

    // States in which a memory request is outstanding and the wait timer runs.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_F2) || (s == ST_A2) || (s == ST_S2);
    endfunction

endpackage

// File: rtl/adder_ctrl_mem_wait_timer.sv
// Wait-cycle counter for memory handshakes. Cleared while no request is
// pending, counts cycles spent waiting for mem_ack.
module mem_wait_timer #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned TMR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [TMR_W-1:0] count,
    output logic             expired
);

    logic [TMR_W-1:0] count_d;
    logic [TMR_W-1:0] count_q;

    // Next count: clear has priority over increment.
    always_comb begin
        // NOTE: assign a default first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign expired = (count_q == TMR_W'(WAIT_MAX));

endmodule

// File: rtl/adder_ctrl_fsm.sv
// Control unit for the adding machine: sequences fetch/decode/execute and
// drives all datapath strobes. Moore outputs, except ld_ir, inc_pc and ld_acc
// which fire only on the cycle memory acknowledges.
module adder_ctrl_fsm
    import adder_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned TMR_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] opcode,
    input  logic       mem_ack,
    output logic       clr_pc,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic       sel_mar,
    output logic       ld_mar,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ld_ir,
    output logic       ld_acc,
    output logic       clr_acc,
    output logic       busy,
    output logic       halted,
    output logic       err
);

    localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(WAIT_MAX - 1);

    state_t           state_d;
    state_t           state_q;
    logic [TMR_W-1:0] wait_cnt;
    logic             wait_expired;
    logic             in_wait;
    logic             ack_ok;
    logic             wait_last;

    // Timer is held at zero outside wait states, so it is always zero on entry.
    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .TMR_W    (TMR_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!in_wait),
        .en      (in_wait && !mem_ack),
        .count   (wait_cnt),
        .expired (wait_expired)
    );

    assign in_wait   = is_wait_state(state_q);
    assign ack_ok    = in_wait && mem_ack && !wait_expired;
    // Last cycle on which an ack is still accepted; no ack here means timeout.
    assign wait_last = (wait_cnt == WAIT_LAST);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALT, ST_ERROR: if (start) state_d = ST_INIT;
            ST_INIT: state_d = ST_F1;
            ST_F1:   state_d = ST_F2;
            ST_F2: begin
                if (ack_ok)         state_d = ST_DEC;
                else if (wait_last) state_d = ST_ERROR;
            end
            ST_DEC: begin
                case (opcode)
                    OP_ADD:  state_d = ST_A1;
                    OP_STO:  state_d = ST_S1;
                    OP_JMP:  state_d = ST_J1;
                    default: state_d = ST_HALT;
                endcase
            end
            ST_A1: state_d = ST_A2;
            ST_A2: begin
                if (ack_ok)         state_d = ST_F1;
                else if (wait_last) state_d = ST_ERROR;
            end
            ST_S1: state_d = ST_S2;
            ST_S2: begin
                if (ack_ok)         state_d = ST_F1;
                else if (wait_last) state_d = ST_ERROR;
            end
            ST_J1:   state_d = ST_F1;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode from the current state; ack-qualified strobes use ack_ok.
    always_comb begin
        clr_pc  = 1'b0;
        ld_pc   = 1'b0;
        inc_pc  = 1'b0;
        sel_mar = 1'b0;
        ld_mar  = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        ld_ir   = 1'b0;
        ld_acc  = 1'b0;
        clr_acc = 1'b0;
        case (state_q)
            ST_INIT: begin
                clr_pc  = 1'b1;
                clr_acc = 1'b1;
            end
            ST_F1: ld_mar = 1'b1;
            ST_F2: begin
                mem_rd = 1'b1;
                ld_ir  = ack_ok;
                inc_pc = ack_ok;
            end
            ST_A1, ST_S1: begin
                ld_mar  = 1'b1;
                sel_mar = 1'b1;
            end
            ST_A2: begin
                mem_rd = 1'b1;
                ld_acc = ack_ok;
            end
            ST_S2:   mem_wr = 1'b1;
            ST_J1:   ld_pc  = 1'b1;
            default: ;
        endcase
    end

    assign busy   = (state_q != ST_IDLE) && (state_q != ST_HALT) && (state_q != ST_ERROR);
    assign halted = (state_q == ST_HALT);
    assign err    = (state_q == ST_ERROR);

endmodule

// File: tb/tb_adder_ctrl_fsm.sv
// Directed bench for adder_ctrl_fsm with WAIT_MAX=4. Each step applies inputs
// just after the falling edge and compares the full output vector against a
// hand-written expectation for that state.
module tb_adder_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] opcode;
    logic       mem_ack;
    logic       clr_pc, ld_pc, inc_pc, sel_mar, ld_mar, mem_rd, mem_wr;
    logic       ld_ir, ld_acc, clr_acc, busy, halted, err;

    adder_ctrl_fsm #(
        .WAIT_MAX (4),
        .TMR_W    (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .opcode  (opcode),
        .mem_ack (mem_ack),
        .clr_pc  (clr_pc),
        .ld_pc   (ld_pc),
        .inc_pc  (inc_pc),
        .sel_mar (sel_mar),
        .ld_mar  (ld_mar),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .ld_ir   (ld_ir),
        .ld_acc  (ld_acc),
        .clr_acc (clr_acc),
        .busy    (busy),
        .halted  (halted),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Bit order: clr_pc ld_pc inc_pc sel_mar ld_mar mem_rd mem_wr ld_ir ld_acc clr_acc busy halted err
    logic [12:0] outs;
    assign outs = {clr_pc, ld_pc, inc_pc, sel_mar, ld_mar, mem_rd, mem_wr,
                   ld_ir, ld_acc, clr_acc, busy, halted, err};

    localparam logic [12:0] E_IDLE  = 13'h0000;
    localparam logic [12:0] E_INIT  = 13'h100C;
    localparam logic [12:0] E_F1    = 13'h0104;
    localparam logic [12:0] E_F2    = 13'h0084;
    localparam logic [12:0] E_F2ACK = 13'h04A4;
    localparam logic [12:0] E_DEC   = 13'h0004;
    localparam logic [12:0] E_A1    = 13'h0304;
    localparam logic [12:0] E_A2    = 13'h0084;
    localparam logic [12:0] E_A2ACK = 13'h0094;
    localparam logic [12:0] E_S1    = 13'h0304;
    localparam logic [12:0] E_S2    = 13'h0044;
    localparam logic [12:0] E_J1    = 13'h0804;
    localparam logic [12:0] E_HALT  = 13'h0002;
    localparam logic [12:0] E_ERR   = 13'h0001;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int inc_cnt = 0;
    int rd_cnt  = 0;
    int acc_cnt = 0;
    int f1_at   = -1;
    int halt_at = -1;
    bit arm     = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step(input string tag, input logic st, input logic [1:0] op,
                        input logic ack, input logic [12:0] exp);
        @(negedge clk);
        start   = st;
        opcode  = op;
        mem_ack = ack;
        cyc++;
        #1;
        check(tag, outs, exp);
        if (inc_pc) inc_cnt++;
        if (mem_rd) rd_cnt++;
        if (ld_acc) acc_cnt++;
    endtask

    // Records the first fetch cycle and the first halted cycle of a program run.
    always @(negedge clk) begin
        #2;
        if (arm) begin
            if (f1_at < 0 && ld_mar && !sel_mar) f1_at = cyc;
            if (halt_at < 0 && halted)           halt_at = cyc;
        end
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        opcode  = 2'b00;
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outs", outs, E_IDLE);
        rst_n = 1'b1;

        step("idle",      0, 2'b00, 0, E_IDLE);
        step("idle_ack",  0, 2'b00, 1, E_IDLE);
        step("idle_hold", 0, 2'b00, 0, E_IDLE);

        // ADD, ADD, STO, HLT with zero-wait memory
        inc_cnt = 0;
        arm     = 1'b1;
        step("start",   1, 2'b00, 0, E_IDLE);
        step("init",    0, 2'b11, 0, E_INIT);
        step("f1_add0", 0, 2'b11, 0, E_F1);
        step("f2_add0", 0, 2'b11, 1, E_F2ACK);
        step("dec_add0",0, 2'b00, 0, E_DEC);
        step("a1_add0", 0, 2'b11, 0, E_A1);
        step("a2_add0", 0, 2'b11, 1, E_A2ACK);
        // start while busy and a spurious ack in DEC must both be ignored
        step("f1_add1_start", 1, 2'b11, 0, E_F1);
        step("f2_add1", 0, 2'b11, 1, E_F2ACK);
        step("dec_add1_ack", 0, 2'b00, 1, E_DEC);
        step("a1_add1", 0, 2'b11, 0, E_A1);
        step("a2_add1", 0, 2'b11, 1, E_A2ACK);
        step("f1_sto",  0, 2'b11, 0, E_F1);
        step("f2_sto",  0, 2'b11, 1, E_F2ACK);
        step("dec_sto", 0, 2'b01, 0, E_DEC);
        step("s1_sto",  0, 2'b11, 0, E_S1);
        step("s2_sto",  0, 2'b11, 1, E_S2);
        step("f1_hlt",  0, 2'b11, 0, E_F1);
        step("f2_hlt",  0, 2'b11, 1, E_F2ACK);
        step("dec_hlt", 0, 2'b11, 0, E_DEC);
        step("halt",    0, 2'b00, 0, E_HALT);
        step("halt_hold", 0, 2'b00, 1, E_HALT);
        arm = 1'b0;
        check("inc_pc_count", 32'(inc_cnt), 32'd4);
        check("halt_latency", 32'(halt_at - f1_at), 32'd18);

        // Restart from HALT, then JMP
        step("halt_start", 1, 2'b00, 0, E_HALT);
        step("init_jmp",   0, 2'b00, 0, E_INIT);
        step("f1_jmp",     0, 2'b00, 0, E_F1);
        step("f2_jmp",     0, 2'b00, 1, E_F2ACK);
        step("dec_jmp",    0, 2'b10, 0, E_DEC);
        step("j1",         0, 2'b00, 0, E_J1);
        step("f1_after_jmp", 0, 2'b00, 0, E_F1);

        // ADD with ack delayed 3 cycles (ack on the last accepted count)
        step("f2_addw",  0, 2'b11, 1, E_F2ACK);
        step("dec_addw", 0, 2'b00, 0, E_DEC);
        step("a1_addw",  0, 2'b11, 0, E_A1);
        rd_cnt  = 0;
        acc_cnt = 0;
        step("a2_wait0", 0, 2'b11, 0, E_A2);
        step("a2_wait1", 0, 2'b11, 0, E_A2);
        step("a2_wait2", 0, 2'b11, 0, E_A2);
        step("a2_ack",   0, 2'b11, 1, E_A2ACK);
        check("a2_rd_cycles", 32'(rd_cnt), 32'd4);
        check("a2_ld_acc_pulses", 32'(acc_cnt), 32'd1);
        step("f1_after_wait", 0, 2'b11, 0, E_F1);

        // STO with no ack: timeout into ERROR
        step("f2_sto_to",  0, 2'b11, 1, E_F2ACK);
        step("dec_sto_to", 0, 2'b01, 0, E_DEC);
        step("s1_sto_to",  0, 2'b11, 0, E_S1);
        step("s2_wait0",   0, 2'b11, 0, E_S2);
        step("s2_wait1",   0, 2'b11, 0, E_S2);
        step("s2_wait2",   0, 2'b11, 0, E_S2);
        step("s2_wait3",   0, 2'b11, 0, E_S2);
        step("error",      0, 2'b11, 1, E_ERR);
        step("error_hold", 0, 2'b11, 0, E_ERR);
        step("error_start",1, 2'b00, 0, E_ERR);
        step("init_after_err", 0, 2'b00, 0, E_INIT);

        // Reset asserted mid-A2 drops the request immediately
        step("f1_rst",  0, 2'b00, 0, E_F1);
        step("f2_rst",  0, 2'b00, 1, E_F2ACK);
        step("dec_rst", 0, 2'b00, 0, E_DEC);
        step("a1_rst",  0, 2'b00, 0, E_A1);
        step("a2_rst",  0, 2'b00, 0, E_A2);
        rst_n = 1'b0;
        #1;
        check("reset_mid_a2", outs, E_IDLE);
        @(negedge clk);
        #1;
        check("reset_held", outs, E_IDLE);
        rst_n = 1'b1;
        step("idle_after_rst",   0, 2'b00, 1, E_IDLE);
        step("idle_no_complete", 0, 2'b00, 0, E_IDLE);
        step("start_after_rst",  1, 2'b00, 0, E_IDLE);
        step("init_after_rst",   0, 2'b00, 0, E_INIT);
        step("f1_after_rst",     0, 2'b00, 0, E_F1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adder_ctrl_fsm.md
# adder_ctrl_fsm

Control unit for the adding machine. It sequences fetch, decode and execute for the 6-bit program counter, MAR, IR, accumulator and memory. It issues all load, increment and clear strobes, and handshakes with memory through a req/ack pair guarded by a timeout. It sits beside the datapath, with its opcode input fed from IR[7:6].

## Interface
- WAIT_MAX, default 15: maximum cycles a memory request may stay pending before the error state is entered (1..255).
- TMR_W, default 8: width of the wait counter.

Ports (clock and reset first):
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; starts or restarts the program. Honoured only in IDLE, HALT and ERROR.
- opcode  in  2  IR[7:6]: 00 ADD, 01 STO, 10 JMP, 11 HLT.
- mem_ack  in  1  memory completion, one-cycle pulse.
- clr_pc  out  1  clears the PC on the next edge.
- ld_pc  out  1  loads the PC from the IR address field.
- inc_pc  out  1  increments the PC.
- sel_mar  out  1  MAR source: 0 = PC, 1 = IR address.
- ld_mar  out  1  loads the MAR.
- mem_rd  out  1  read request, held until ack.
- mem_wr  out  1  write request (stores the accumulator), held until ack.
- ld_ir  out  1  loads the IR from the memory data bus.
- ld_acc  out  1  acc <= acc + mem data.
- clr_acc  out  1  clears the accumulator.
- busy  out  1  high in every state except IDLE, HALT and ERROR.
- halted  out  1  high in HALT.
- err  out  1  high in ERROR.

## Operation
- The FSM is Moore, except that ld_ir, inc_pc and ld_acc are qualified by mem_ack.
- States: IDLE, INIT, F1, F2, DEC, A1, A2, S1, S2, J1, HALT, ERROR.
- Transitions:
  - IDLE / HALT / ERROR, start=1 -> INIT. Otherwise stay.
  - INIT: clr_pc=1, clr_acc=1 -> F1.
  - F1: ld_mar=1, sel_mar=0 -> F2.
  - F2: mem_rd=1. When mem_ack=1: ld_ir=1, inc_pc=1 -> DEC.
  - DEC: no strobes. Opcode 00 -> A1, 01 -> S1, 10 -> J1, 11 -> HALT.
  - A1: ld_mar=1, sel_mar=1 -> A2.
  - A2: mem_rd=1. When mem_ack=1: ld_acc=1 -> F1.
  - S1: ld_mar=1, sel_mar=1 -> S2.
  - S2: mem_wr=1. When mem_ack=1 -> F1.
  - J1: ld_pc=1 -> F1.
- Wait timer:
  - Clears on entry to F2, A2 or S2, and increments each cycle there without ack.
  - Ack arriving on the cycle the count reaches WAIT_MAX-1 is still accepted.
  - When the count reaches WAIT_MAX without ack -> ERROR. mem_rd and mem_wr drop and no strobe is issued.
- Exclusivity: ld_pc, inc_pc and clr_pc are never asserted together. mem_rd and mem_wr are never asserted together.
- PC wrap: inc_pc at PC=63 wraps to 0. This is the datapath's concern; the FSM takes no special action.
- Ignored inputs:
  - mem_ack outside F2, A2 and S2.
  - start while busy.
- The opcode is sampled only in DEC.

## Timing
- Reset (asynchronous, rst_n=0): state=IDLE, wait timer=0, every output 0. The same values hold in IDLE. A reset mid-request drops mem_rd/mem_wr immediately, with no completion.
- First fetch: F1 is entered 2 cycles after the start pulse (IDLE -> INIT -> F1).
- Instruction lengths with zero-wait memory (ack in the first cycle of the request):
  - ADD: 5 cycles, F1 to F1.
  - STO: 5 cycles, F1 to F1.
  - JMP: 4 cycles, F1 to F1.
  - HLT: 3 cycles, F1 to HALT.
- Each extra wait cycle adds 1 cycle.
- HALT and ERROR hold all strobes low. start from HALT restarts from address 0 (via INIT).

## Structure
- Package adder_ctrl_pkg holds the state enum and the opcode constants OP_ADD, OP_STO, OP_JMP, OP_HLT.
- One sub-module, mem_wait_timer. Inputs: clk, rst_n, clr, en. Outputs: count and expired (count == WAIT_MAX).
- Next-state logic and output decode live in adder_ctrl_fsm.

## Test plan
- Reset and start: rst_n low mid-A2 -> all outputs 0 immediately. Start pulse -> clr_pc and clr_acc high 1 cycle later, ld_mar with sel_mar=0 the cycle after that.
- Program ADD, ADD, STO, HLT with zero-wait ack: strobe sequence matches the state list, halted rises 18 cycles after F1 first entry (5+5+5+3), and inc_pc is pulsed exactly 4 times.
- JMP with opcode 10: ld_pc=1 for exactly 1 cycle in J1, no inc_pc in J1, then F1 with sel_mar=0.
- Wait states in A2 with ack delayed 3 cycles: mem_rd is held 4 cycles and ld_acc pulses once, coincident with ack.
- Timeout with WAIT_MAX=4 and no ack in S2: after 4 cycles err=1, mem_wr=0 and busy=0. Start then -> INIT, err=0.
- Start while busy, and a spurious mem_ack in DEC: both ignored, the state trace is unchanged and no extra strobes appear.
